gshare_spec_bp: RTL and testbench
=================================

Name: gshare_spec_bp

Overview:
- Parametrised gshare conditional-branch predictor for the CVA6 frontend; next generation of the global-history BHT.
- Adds a speculative global history register (GHR) shifted at fetch, with single-cycle repair on mispredict from the snapshot carried with each branch.
- History length is configurable and folded into the index; counter width is configurable.
- Flush is a multi-cycle table sweep with a ready handshake.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core config. Uses VLEN, RVC and INSTR_PER_FETCH (IPF).
- NR_ENTRIES, 1024, total counters. NR_ROWS = NR_ENTRIES/IPF, a power of two.
- HIST_BITS, 12, GHR length, >= 2.
- CTR_BITS, 2, saturating counter width, >= 2.
- Derived values:
  - IDX_W = $clog2(NR_ROWS)
  - OFFSET = RVC ? 1 : 2
  - ROW_ADDR_BITS = $clog2(IPF)
  - WEAK_T = 1 << (CTR_BITS-1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- flush_bp_i  in  1  start table flush
- debug_mode_i  in  1  suppresses all state updates
- vpc_i  in  VLEN  fetch PC
- fetch_valid_i  in  1  fetch accepted this cycle; shift speculative GHR
- spec_taken_i  in  1  frontend's final taken decision for this fetch
- pred_valid_o  out  IPF  per-slot entry valid
- pred_taken_o  out  IPF  per-slot counter MSB
- pred_index_o  out  IDX_W  row index used (metadata)
- pred_ghr_o  out  HIST_BITS  speculative GHR before this fetch's shift (metadata)
- ready_o  out  1  0 while flushing
- upd_valid_i  in  1  resolved conditional branch
- upd_pc_i  in  VLEN  branch PC (column select)
- upd_index_i  in  IDX_W  metadata index
- upd_ghr_i  in  HIST_BITS  metadata GHR snapshot
- upd_taken_i  in  1  resolved direction
- upd_mispredict_i  in  1  direction mispredicted

Behaviour:
- Table is a flop array table[NR_ROWS][IPF] of {valid, ctr[CTR_BITS-1:0]}.
  - Reset (async): every entry valid=0, ctr=WEAK_T; spec_ghr_q=0; FSM=IDLE; ready_o=1; pred_valid_o=0.
- Fold function: fold(g) = XOR of consecutive IDX_W-bit chunks of g, starting from bit 0; the last chunk is zero-padded at the MSBs.
- Prediction (combinational, same cycle as vpc_i):
  - index = vpc_i[IDX_W+ROW_ADDR_BITS+OFFSET-1 : ROW_ADDR_BITS+OFFSET] ^ fold(spec_ghr_q)
  - pred_valid_o[i] = table[index][i].valid & (state==IDLE)
  - pred_taken_o[i] = table[index][i].ctr[CTR_BITS-1]
  - pred_index_o = index; pred_ghr_o = spec_ghr_q
- Speculative GHR, priority order (highest first):
  1. Flush or reset: spec_ghr <= 0.
  2. upd_valid_i & upd_mispredict_i & !debug_mode_i: spec_ghr <= {upd_ghr_i[HIST_BITS-2:0], upd_taken_i}. A simultaneous fetch shift is discarded.
  3. fetch_valid_i & ready_o & !debug_mode_i: spec_ghr <= {spec_ghr_q[HIST_BITS-2:0], spec_taken_i}.
  4. Otherwise hold.
- Table update (upd_valid_i & !debug_mode_i & state==IDLE):
  - Target entry: row upd_index_i, column upd_pc_i[ROW_ADDR_BITS+OFFSET-1:OFFSET] (column 0 if !RVC).
  - Set valid=1. Counter does +1 if taken, -1 if not, saturating at 0 and 2^CTR_BITS-1.
  - Write visible from the next cycle. A same-cycle prediction of the same entry sees the old value.
- FSM states:
  - IDLE --flush_bp_i--> FLUSH, with row counter=0.
  - FLUSH: each cycle writes row counter row, all columns, to {0, WEAK_T}, then increments the counter.
  - After row NR_ROWS-1 is written, return to IDLE. ready_o=1 on the next cycle; flush takes exactly NR_ROWS cycles.
  - flush_bp_i asserted during FLUSH restarts at row 0.
  - While in FLUSH: ready_o=0, updates dropped, fetch shifts dropped. Mispredict repair still applies unless a flush starts in the same cycle.
- Reset mid-flush returns to IDLE with the full reset state.

Optional Feature:
- Macro GBP_BYPASS_EN.
- Defined: in IDLE, an accepted update whose row equals the current index forwards to the prediction of that column in the same cycle: valid=1, taken=MSB of the new counter.
- Undefined: no forwarding; the old value is seen for one cycle, as specified above.

Test Plan:
- Config for all scenarios: NR_ENTRIES=16, IPF=2, HIST_BITS=5, CTR_BITS=2, RVC=1. Index = pc[4:2] ^ fold.
- Reset, vpc_i=0x8 -> index=2, pred_valid_o=00, ready_o=1, pred_ghr_o=00000.
- Saturation: three taken updates to idx 2, pc 0x8, column 0 -> ctr 2→3→3, pred_taken_o[0]=1, pred_valid_o[0]=1. Then two not-taken -> ctr 1, pred_taken_o[0]=0.
- History: fetch_valid with spec_taken 1,1,0 -> spec_ghr=00110, fold=110; vpc_i=0x8 -> pred_index_o=4.
- Repair: upd_ghr_i=01011, taken=1, mispredict=1, with fetch_valid_i=1 in the same cycle -> next pred_ghr_o=10111.
- Flush: one-cycle flush_bp_i -> ready_o=0 for exactly 8 cycles, pred_valid_o=00, update injected at cycle 3 dropped. Afterwards all counters=2 and valid=0. A second flush at cycle 4 extends the sweep to 12 cycles total.
- Debug: update with debug_mode_i=1 -> table and spec_ghr unchanged. With GBP_BYPASS_EN, an update plus prediction to the same entry shows valid=1 in the same cycle.

Source files
------------

// File: rtl/gshare_spec_bp.sv
// gshare conditional-branch predictor with speculative GHR, mispredict repair and swept flush.
// Optional `GBP_BYPASS_EN forwards a same-cycle update into the matching prediction slot.
module gshare_spec_bp #(
    parameter int unsigned  VLEN            = 64,
    parameter bit           RVC             = 1'b1,
    parameter int unsigned  INSTR_PER_FETCH = 2,
    parameter int unsigned  NR_ENTRIES      = 1024,
    parameter int unsigned  HIST_BITS       = 12,
    parameter int unsigned  CTR_BITS        = 2,
    localparam int unsigned IPF             = INSTR_PER_FETCH,
    localparam int unsigned NR_ROWS         = NR_ENTRIES / IPF,
    localparam int unsigned IDX_W           = $clog2(NR_ROWS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_bp_i,
    input  logic                 debug_mode_i,
    input  logic [VLEN-1:0]      vpc_i,
    input  logic                 fetch_valid_i,
    input  logic                 spec_taken_i,
    output logic [IPF-1:0]       pred_valid_o,
    output logic [IPF-1:0]       pred_taken_o,
    output logic [IDX_W-1:0]     pred_index_o,
    output logic [HIST_BITS-1:0] pred_ghr_o,
    output logic                 ready_o,
    input  logic                 upd_valid_i,
    input  logic [VLEN-1:0]      upd_pc_i,
    input  logic [IDX_W-1:0]     upd_index_i,
    input  logic [HIST_BITS-1:0] upd_ghr_i,
    input  logic                 upd_taken_i,
    input  logic                 upd_mispredict_i
);

    localparam int unsigned OFFSET        = RVC ? 1 : 2;
    localparam int unsigned ROW_ADDR_BITS = $clog2(IPF);
    localparam int unsigned COL_W         = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
    localparam int unsigned CHUNKS        = (HIST_BITS + IDX_W - 1) / IDX_W;
    localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     row_q;
    logic [HIST_BITS-1:0] spec_ghr_q;
    logic                 valid_q [NR_ROWS][IPF];
    logic [CTR_BITS-1:0]  ctr_q   [NR_ROWS][IPF];

    logic                               idle;
    logic [CHUNKS-1:0][IDX_W-1:0]       ghr_pad;
    logic [IDX_W-1:0]                   fold;
    logic [IDX_W-1:0]                   index;
    logic [COL_W-1:0]                   upd_col;
    logic                               upd_en;
    logic [CTR_BITS-1:0]                upd_ctr_old;
    logic [CTR_BITS-1:0]                upd_ctr_new;
    logic                               unused_pc_bits;

    assign idle           = (state_q == StIdle);
    assign ready_o        = idle;
    assign unused_pc_bits = ^{vpc_i, upd_pc_i};

    // Zero-pad the history to a whole number of index-wide chunks, then XOR them together.
    assign ghr_pad = (CHUNKS * IDX_W)'(spec_ghr_q);
    always_comb begin
        fold = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            fold = fold ^ ghr_pad[c];
        end
    end

    assign index        = vpc_i[IDX_W+ROW_ADDR_BITS+OFFSET-1:ROW_ADDR_BITS+OFFSET] ^ fold;
    assign pred_index_o = index;
    assign pred_ghr_o   = spec_ghr_q;

    if (ROW_ADDR_BITS == 0 || !RVC) begin : g_col_zero
        assign upd_col = '0;
    end else begin : g_col_pc
        assign upd_col = upd_pc_i[ROW_ADDR_BITS+OFFSET-1:OFFSET];
    end

    assign upd_en      = upd_valid_i & ~debug_mode_i & idle;
    assign upd_ctr_old = ctr_q[upd_index_i][upd_col];

    always_comb begin
        upd_ctr_new = upd_ctr_old;
        if (upd_taken_i) begin
            if (upd_ctr_old != CTR_MAX) upd_ctr_new = upd_ctr_old + CTR_BITS'(1);
        end else if (upd_ctr_old != '0) begin
            upd_ctr_new = upd_ctr_old - CTR_BITS'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < IPF; i++) begin
            pred_valid_o[i] = valid_q[index][i] & idle;
            pred_taken_o[i] = ctr_q[index][i][CTR_BITS-1];
        end
`ifdef GBP_BYPASS_EN
        if (upd_en && (upd_index_i == index)) begin
            pred_valid_o[upd_col] = 1'b1;
            pred_taken_o[upd_col] = upd_ctr_new[CTR_BITS-1];
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            row_q      <= '0;
            spec_ghr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (flush_bp_i) begin
                        state_q <= StFlush;
                        row_q   <= '0;
                    end
                end
                StFlush: begin
                    if (flush_bp_i) begin
                        row_q <= '0;
                    end else if (row_q == IDX_W'(NR_ROWS - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        row_q <= row_q + IDX_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Repair outranks the fetch shift; a starting flush outranks both.
            if (flush_bp_i) begin
                spec_ghr_q <= '0;
            end else if (upd_valid_i && upd_mispredict_i && !debug_mode_i) begin
                spec_ghr_q <= {upd_ghr_i[HIST_BITS-2:0], upd_taken_i};
            end else if (fetch_valid_i && idle && !debug_mode_i) begin
                spec_ghr_q <= {spec_ghr_q[HIST_BITS-2:0], spec_taken_i};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NR_ROWS; r++) begin
                for (int c = 0; c < IPF; c++) begin
                    valid_q[r][c] <= 1'b0;
                    ctr_q[r][c]   <= WEAK_T;
                end
            end
        end else if (!idle) begin
            for (int c = 0; c < IPF; c++) begin
                valid_q[row_q][c] <= 1'b0;
                ctr_q[row_q][c]   <= WEAK_T;
            end
        end else if (upd_en) begin
            valid_q[upd_index_i][upd_col] <= 1'b1;
            ctr_q[upd_index_i][upd_col]   <= upd_ctr_new;
        end
    end

endmodule

// File: tb/tb_gshare_spec_bp.sv
// Directed bench for gshare_spec_bp: 16 entries, 2 slots per fetch, 5-bit history, 2-bit counters.
module tb_gshare_spec_bp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_bp;
    logic        debug_mode;
    logic [31:0] vpc;
    logic        fetch_valid;
    logic        spec_taken;
    logic [1:0]  pred_valid;
    logic [1:0]  pred_taken;
    logic [2:0]  pred_index;
    logic [4:0]  pred_ghr;
    logic        ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [2:0]  upd_index;
    logic [4:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    int passed = 0;
    int total  = 0;

    gshare_spec_bp #(
        .VLEN            (32),
        .RVC             (1'b1),
        .INSTR_PER_FETCH (2),
        .NR_ENTRIES      (16),
        .HIST_BITS       (5),
        .CTR_BITS        (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_bp_i       (flush_bp),
        .debug_mode_i     (debug_mode),
        .vpc_i            (vpc),
        .fetch_valid_i    (fetch_valid),
        .spec_taken_i     (spec_taken),
        .pred_valid_o     (pred_valid),
        .pred_taken_o     (pred_taken),
        .pred_index_o     (pred_index),
        .pred_ghr_o       (pred_ghr),
        .ready_o          (ready),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_index_i      (upd_index),
        .upd_ghr_i        (upd_ghr),
        .upd_taken_i      (upd_taken),
        .upd_mispredict_i (upd_mispredict)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [2:0] idx, input logic [31:0] pc, input logic taken);
        upd_valid = 1'b1; upd_index = idx; upd_pc = pc; upd_taken = taken; upd_mispredict = 1'b0;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        vpc = 32'h8;
        #1;
        total++; if (pred_index !== 3'd2) $display("FAIL reset_index: got %0d want 2", pred_index); else passed++;
        total++; if (pred_valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", pred_valid); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
        total++; if (pred_ghr !== 5'b00000) $display("FAIL reset_ghr: got %b want 00000", pred_ghr); else passed++;
    endtask

    task automatic test_saturation();
        vpc = 32'h8;
        repeat (3) do_update(3'd2, 32'h8, 1'b1);
        total++; if (pred_valid !== 2'b01) $display("FAIL sat_valid: got %b want 01", pred_valid); else passed++;
        total++; if (pred_taken !== 2'b11) $display("FAIL sat_hi: got %b want 11", pred_taken); else passed++;
        repeat (2) do_update(3'd2, 32'h8, 1'b0);
        total++; if (pred_taken !== 2'b10) $display("FAIL sat_down: got %b want 10", pred_taken); else passed++;
        repeat (2) do_update(3'd2, 32'h8, 1'b0);
        repeat (2) do_update(3'd2, 32'h8, 1'b1);
        total++; if (pred_taken !== 2'b11) $display("FAIL sat_lo: got %b want 11", pred_taken); else passed++;
        do_update(3'd2, 32'h8, 1'b0);
        total++; if (pred_taken !== 2'b10) $display("FAIL sat_end: got %b want 10", pred_taken); else passed++;
    endtask

    task automatic test_history();
        fetch_valid = 1'b1; spec_taken = 1'b1;
        step();
        total++; if (pred_ghr !== 5'b00001) $display("FAIL hist_first: got %b want 00001", pred_ghr); else passed++;
        step();
        spec_taken = 1'b0;
        step();
        fetch_valid = 1'b0; vpc = 32'h8;
        #1;
        total++; if (pred_ghr !== 5'b00110) $display("FAIL hist_ghr: got %b want 00110", pred_ghr); else passed++;
        total++; if (pred_index !== 3'd4) $display("FAIL hist_index: got %0d want 4", pred_index); else passed++;
        total++; if (pred_valid !== 2'b00) $display("FAIL hist_valid: got %b want 00", pred_valid); else passed++;
    endtask

    task automatic test_repair();
        upd_valid = 1'b1; upd_index = 3'd5; upd_pc = 32'h2; upd_taken = 1'b1;
        upd_mispredict = 1'b1; upd_ghr = 5'b01011;
        fetch_valid = 1'b1; spec_taken = 1'b0;
        step();
        upd_valid = 1'b0; upd_mispredict = 1'b0; fetch_valid = 1'b0; vpc = 32'h0;
        #1;
        total++; if (pred_ghr !== 5'b10111) $display("FAIL repair_ghr: got %b want 10111", pred_ghr); else passed++;
        total++; if (pred_index !== 3'd5) $display("FAIL repair_index: got %0d want 5", pred_index); else passed++;
        total++; if (pred_valid !== 2'b10) $display("FAIL repair_valid: got %b want 10", pred_valid); else passed++;
        total++; if (pred_taken !== 2'b11) $display("FAIL repair_taken: got %b want 11", pred_taken); else passed++;
    endtask

    task automatic test_flush();
        int low = 0;
        flush_bp = 1'b1; fetch_valid = 1'b1; spec_taken = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            flush_bp = 1'b0; upd_valid = 1'b0;
            if (ready) break;
            low++;
            total++; if (pred_valid !== 2'b00) $display("FAIL flush_valid: got %b want 00", pred_valid); else passed++;
            total++; if (pred_ghr !== 5'b00000) $display("FAIL flush_ghr: got %b want 00000", pred_ghr); else passed++;
            if (low == 3) begin
                upd_valid = 1'b1; upd_index = 3'd0; upd_pc = 32'h0; upd_taken = 1'b1;
            end
        end
        fetch_valid = 1'b0;
        total++; if (low !== 8) $display("FAIL flush_len: got %0d want 8", low); else passed++;
        for (int i = 0; i < 8; i++) begin
            vpc = 32'(i) << 2;
            #1;
            total++; if (pred_valid !== 2'b00) $display("FAIL flush_row%0d_valid: got %b want 00", i, pred_valid); else passed++;
            total++; if (pred_taken !== 2'b11) $display("FAIL flush_row%0d_ctr: got %b want 11", i, pred_taken); else passed++;
        end
    endtask

    task automatic test_flush_restart();
        int low = 0;
        flush_bp = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            flush_bp = 1'b0;
            if (ready) break;
            low++;
            if (low == 4) flush_bp = 1'b1;
        end
        total++; if (low !== 12) $display("FAIL flush_restart_len: got %0d want 12", low); else passed++;
    endtask

    task automatic test_debug();
        debug_mode = 1'b1;
        upd_valid = 1'b1; upd_index = 3'd2; upd_pc = 32'h8; upd_taken = 1'b0;
        upd_mispredict = 1'b1; upd_ghr = 5'b11111;
        fetch_valid = 1'b1; spec_taken = 1'b1;
        step();
        debug_mode = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; fetch_valid = 1'b0;
        vpc = 32'h8;
        #1;
        total++; if (pred_ghr !== 5'b00000) $display("FAIL debug_ghr: got %b want 00000", pred_ghr); else passed++;
        total++; if (pred_valid !== 2'b00) $display("FAIL debug_valid: got %b want 00", pred_valid); else passed++;
        total++; if (pred_taken !== 2'b11) $display("FAIL debug_ctr: got %b want 11", pred_taken); else passed++;
    endtask

    task automatic test_bypass();
        vpc = 32'h8;
        upd_valid = 1'b1; upd_index = 3'd2; upd_pc = 32'h8; upd_taken = 1'b0; upd_mispredict = 1'b0;
        #1;
`ifdef GBP_BYPASS_EN
        total++; if (pred_valid !== 2'b01) $display("FAIL bypass_valid: got %b want 01", pred_valid); else passed++;
        total++; if (pred_taken !== 2'b10) $display("FAIL bypass_taken: got %b want 10", pred_taken); else passed++;
`else
        total++; if (pred_valid !== 2'b00) $display("FAIL same_cycle_valid: got %b want 00", pred_valid); else passed++;
        total++; if (pred_taken !== 2'b11) $display("FAIL same_cycle_taken: got %b want 11", pred_taken); else passed++;
`endif
        step();
        upd_valid = 1'b0;
        #1;
        total++; if (pred_valid !== 2'b01) $display("FAIL after_upd_valid: got %b want 01", pred_valid); else passed++;
        total++; if (pred_taken !== 2'b10) $display("FAIL after_upd_taken: got %b want 10", pred_taken); else passed++;
    endtask

    task automatic test_reset_mid_flush();
        flush_bp = 1'b1;
        step();
        flush_bp = 1'b0;
        step();
        total++; if (ready !== 1'b0) $display("FAIL midflush_busy: got %b want 0", ready); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (ready !== 1'b1) $display("FAIL midflush_reset_ready: got %b want 1", ready); else passed++;
        total++; if (pred_valid !== 2'b00) $display("FAIL midflush_reset_valid: got %b want 00", pred_valid); else passed++;
        #2;
        rst_n = 1'b1;
        step();
        total++; if (ready !== 1'b1) $display("FAIL midflush_idle: got %b want 1", ready); else passed++;
    endtask

    initial begin
        rst_n = 1'b0; flush_bp = 1'b0; debug_mode = 1'b0; vpc = 32'h8;
        fetch_valid = 1'b0; spec_taken = 1'b0; upd_valid = 1'b0; upd_pc = '0;
        upd_index = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_saturation();
        test_history();
        test_repair();
        test_flush();
        test_flush_restart();
        test_debug();
        test_bypass();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
